// File: rtl/ex_stage_pkg.sv
// Shared constants for the EX stage: bus widths, StallBus encoding, one-hot
// field bit indices and the divider FSM state type.
package ex_stage_pkg;

  localparam int ID_TO_EX_WD        = 161;
  localparam int EX_TO_MEM_WD       = 76;
  localparam int EX_TO_ID_WD        = 38;
  localparam int STALLBUS_WD        = 6;
  localparam int LOAD_SRAM_DATA_WD  = 5;
  localparam int STORE_SRAM_DATA_WD = 3;
  localparam int DIV_CYCLES         = 32;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam int   STALL_EX  = 2;
  localparam int   STALL_MEM = 3;

  // alu_op one-hot, MSB first
  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  localparam int MEM_LB  = 7;
  localparam int MEM_LH  = 6;
  localparam int MEM_LW  = 5;
  localparam int MEM_LBU = 4;
  localparam int MEM_LHU = 3;
  localparam int MEM_SB  = 2;
  localparam int MEM_SH  = 1;
  localparam int MEM_SW  = 0;

  localparam int HILO_DIV  = 5;
  localparam int HILO_DIVU = 4;
  localparam int HILO_MFHI = 3;
  localparam int HILO_MFLO = 2;
  localparam int HILO_MTHI = 1;
  localparam int HILO_MTLO = 0;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_stage_div_iter.sv
// Iterative restoring divider, one quotient bit per cycle on magnitudes.
// Optional macro EX_DIV_ZERO_SKIP_EN: zero divisor/dividend finishes after one busy cycle.
module div_iter
  import ex_stage_pkg::*;
#(
  parameter int CYCLES = DIV_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        clear,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        stallreq,
  output logic        res_we,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int CW = $clog2(CYCLES + 1);

  div_state_e    state_q, state_d;
  logic [31:0]   rem_q, quo_q, dsr_q, dvd_q;
  logic [CW-1:0] cnt_q;
  logic          neg_q_q, neg_r_q, dz_q;
  logic [32:0]   trial, diff;
  logic [31:0]   rem_n, quo_n;
  logic          ge, last, a_neg, b_neg;

  assign a_neg = signed_op & dividend[31];
  assign b_neg = signed_op & divisor[31];

  // dividend bits shift out of quo_q into the partial remainder
  assign trial = {rem_q, quo_q[31]};
  assign diff  = trial - {1'b0, dsr_q};
  assign ge    = ~diff[32];
  assign rem_n = ge ? diff[31:0] : trial[31:0];
  assign quo_n = {quo_q[30:0], ge};

`ifdef EX_DIV_ZERO_SKIP_EN
  logic skip_q;
  assign last = skip_q || (cnt_q == CW'(CYCLES - 1));
`else
  assign last = (cnt_q == CW'(CYCLES - 1));
`endif

  assign quotient  = dz_q ? 32'hFFFF_FFFF : neg_if(neg_q_q, quo_n);
  assign remainder = dz_q ? dvd_q : neg_if(neg_r_q, rem_n);

  always_comb begin
    state_d  = state_q;
    stallreq = 1'b0;
    res_we   = 1'b0;
    unique case (state_q)
      DIV_IDLE: if (req) begin
        state_d  = DIV_BUSY;
        stallreq = 1'b1;
      end
      DIV_BUSY: begin
        stallreq = 1'b1;
        if (last) begin
          state_d = DIV_DONE;
          res_we  = 1'b1;
        end
      end
      DIV_DONE: if (clear) state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DIV_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      dvd_q   <= '0;
      cnt_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      dz_q    <= 1'b0;
`ifdef EX_DIV_ZERO_SKIP_EN
      skip_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == DIV_IDLE && req) begin
        rem_q   <= '0;
        quo_q   <= neg_if(a_neg, dividend);
        dsr_q   <= neg_if(b_neg, divisor);
        dvd_q   <= dividend;
        cnt_q   <= '0;
        neg_q_q <= a_neg ^ b_neg;
        neg_r_q <= a_neg;
        dz_q    <= (divisor == 32'd0);
`ifdef EX_DIV_ZERO_SKIP_EN
        skip_q  <= (divisor == 32'd0) || (dividend == 32'd0);
`endif
      end else if (state_q == DIV_BUSY) begin
        rem_q <= rem_n;
        quo_q <= quo_n;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, ALU, data-SRAM request, HI/LO and divider.
// Optional macro EX_DIV_ZERO_SKIP_EN is consumed by div_iter.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [STALLBUS_WD-1:0]        stall,
  input  logic [ID_TO_EX_WD-1:0]        id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0]       ex_to_mem_bus,
  output logic [EX_TO_ID_WD-1:0]        ex_to_id_bus,
  output logic [LOAD_SRAM_DATA_WD-1:0]  load_sram_ex_data,
  output logic [STORE_SRAM_DATA_WD-1:0] store_sram_ex_data,
  output logic                          data_sram_en,
  output logic [3:0]                    data_sram_wen,
  output logic [31:0]                   data_sram_addr,
  output logic [31:0]                   data_sram_wdata,
  output logic                          stallreq_for_ex
);

  logic [ID_TO_EX_WD-1:0] id_ex_q;
  logic        adv;
  logic [31:0] pc, src1, src2, store_data;
  logic [11:0] alu_op;
  logic [7:0]  mem_op;
  logic [5:0]  hilo_op;
  logic        rf_we, rf_we_eff, sel_rf_res;
  logic [4:0]  rf_waddr;

  // the EX instruction leaves on both a load and a bubble
  assign adv = (stall[STALL_EX] == NO_STOP) || (stall[STALL_MEM] == NO_STOP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              id_ex_q <= '0;
    else if (stall[STALL_EX] == NO_STOP)   id_ex_q <= id_to_ex_bus;
    else if (stall[STALL_MEM] == NO_STOP)  id_ex_q <= '0;
  end

  assign {pc, alu_op, src1, src2, store_data, mem_op, hilo_op,
          rf_we, rf_waddr, sel_rf_res} = id_ex_q;

  logic [31:0] alu_res;
  always_comb begin
    alu_res = 32'd0;
    if      (alu_op[ALU_ADD])  alu_res = src1 + src2;
    else if (alu_op[ALU_SUB])  alu_res = src1 - src2;
    else if (alu_op[ALU_SLT])  alu_res = {31'd0, $signed(src1) < $signed(src2)};
    else if (alu_op[ALU_SLTU]) alu_res = {31'd0, src1 < src2};
    else if (alu_op[ALU_AND])  alu_res = src1 & src2;
    else if (alu_op[ALU_NOR])  alu_res = ~(src1 | src2);
    else if (alu_op[ALU_OR])   alu_res = src1 | src2;
    else if (alu_op[ALU_XOR])  alu_res = src1 ^ src2;
    else if (alu_op[ALU_SLL])  alu_res = src2 << src1[4:0];
    else if (alu_op[ALU_SRL])  alu_res = src2 >> src1[4:0];
    else if (alu_op[ALU_SRA])  alu_res = $signed(src2) >>> src1[4:0];
    else if (alu_op[ALU_LUI])  alu_res = {src2[15:0], 16'd0};
  end

  logic        is_div, div_we;
  logic [31:0] hi_q, lo_q, div_q, div_r, ex_result;

  assign is_div    = hilo_op[HILO_DIV] | hilo_op[HILO_DIVU];
  assign rf_we_eff = rf_we & ~is_div;

  div_iter #(.CYCLES(DIV_CYCLES)) u_div (
    .clk       (clk),
    .rst       (rst),
    .req       (is_div),
    .clear     (adv),
    .signed_op (hilo_op[HILO_DIV]),
    .dividend  (src1),
    .divisor   (src2),
    .stallreq  (stallreq_for_ex),
    .res_we    (div_we),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (div_we) begin
      hi_q <= div_r;
      lo_q <= div_q;
    end else if (adv) begin
      if (hilo_op[HILO_MTHI]) hi_q <= src1;
      if (hilo_op[HILO_MTLO]) lo_q <= src1;
    end
  end

  always_comb begin
    ex_result = alu_res;
    if      (hilo_op[HILO_MFHI]) ex_result = hi_q;
    else if (hilo_op[HILO_MFLO]) ex_result = lo_q;
  end

  logic       is_byte, is_half, is_word, is_store, mem_en;
  logic [3:0] lane;

  assign is_byte  = mem_op[MEM_LB] | mem_op[MEM_LBU] | mem_op[MEM_SB];
  assign is_half  = mem_op[MEM_LH] | mem_op[MEM_LHU] | mem_op[MEM_SH];
  assign is_word  = mem_op[MEM_LW] | mem_op[MEM_SW];
  assign is_store = mem_op[MEM_SB] | mem_op[MEM_SH] | mem_op[MEM_SW];
  assign mem_en   = |mem_op;

  always_comb begin
    lane = 4'b0000;
    if      (is_byte) lane = 4'b0001 << ex_result[1:0];
    else if (is_half) lane = ex_result[1] ? 4'b1100 : 4'b0011;
    else if (is_word) lane = 4'b1111;
  end

  always_comb begin
    data_sram_wdata = store_data;
    if      (mem_op[MEM_SB]) data_sram_wdata = {4{store_data[7:0]}};
    else if (mem_op[MEM_SH]) data_sram_wdata = {2{store_data[15:0]}};
  end

  assign data_sram_en       = mem_en;
  assign data_sram_wen      = is_store ? lane : 4'b0000;
  assign data_sram_addr     = ex_result;
  assign load_sram_ex_data  = mem_op[MEM_LB:MEM_LHU];
  assign store_sram_ex_data = mem_op[MEM_SB:MEM_SW];

  assign ex_to_mem_bus = {pc, mem_en, lane, sel_rf_res, rf_we_eff, rf_waddr, ex_result};
  assign ex_to_id_bus  = {rf_we_eff, rf_waddr, ex_result};

  logic unused_stall;
  assign unused_stall = ^{stall[5:4], stall[1:0]};

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the 5-stage in-order core; sits between ID and MEM.
Registers the ID-to-EX bus and computes the ALU result. Issues the data-SRAM request for loads and stores, one cycle ahead of MEM sampling data_sram_rdata.
Owns the HI/LO registers and an iterative 32-cycle divider, stalling the front of the pipe while a divide runs.
Produces the EX-to-MEM bus, load/store sideband and EX-to-ID forwarding bus.

Parameters:
ID_TO_EX_WD, 161, width of incoming bus (shared package constant)
EX_TO_MEM_WD, 76, width of outgoing bus
DIV_CYCLES, 32, divider iterations

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
stall  in  6  StallBus; stall[2]=EX, stall[3]=MEM; Stop=1
id_to_ex_bus  in  161  {pc[160:129], alu_op[128:117], alu_src1[116:85], alu_src2[84:53], store_data[52:21], mem_op[20:13], hilo_op[12:7], rf_we[6], rf_waddr[5:1], sel_rf_res[0]}
ex_to_mem_bus  out  76  {pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}
ex_to_id_bus  out  38  {rf_we, rf_waddr, ex_result} for forwarding
load_sram_ex_data  out  5  {lb, lh, lw, lbu, lhu}
store_sram_ex_data  out  3  {sb, sh, sw}
data_sram_en  out  1  SRAM access enable
data_sram_wen  out  4  byte write strobes
data_sram_addr  out  32  byte address = ex_result
data_sram_wdata  out  32  lane-replicated store data
stallreq_for_ex  out  1  divider busy; controller drives stall=6'b001111

Behaviour:
- Pipeline register: rst low -> 0 (async).
- stall[2]=Stop and stall[3]=NoStop -> load 0 (bubble).
- stall[2]=NoStop -> load id_to_ex_bus.
- Otherwise hold.
- All outputs are combinational from the register, HI/LO and divider state, so every output is 0 after reset.
- alu_op is one-hot {add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui}, MSB first.
  - Shifts use alu_src1[4:0] as the amount on alu_src2.
  - lui = {alu_src2[15:0], 16'b0}.
  - All-zero alu_op -> result 0.
  - No overflow trapping.
- mem_op is {lb, lh, lw, lbu, lhu, sb, sh, sw}; the address is the add result. Lane mask:
  - byte: 1<<addr[1:0]
  - half: addr[1] ? 1100 : 0011
  - word: 1111
- data_ram_en = any mem_op bit.
- Bus data_ram_wen = lane mask for loads AND stores; MEM uses it for load lane selection.
- data_sram_wen = lane mask for stores only, 0 for loads.
- Store data is replicated: sb {4{b}}, sh {2{h}}, sw as is. Misalignment is not checked.
- hilo_op is {div, divu, mfhi, mflo, mthi, mtlo}.
  - mfhi/mflo: ex_result = HI/LO.
  - mthi/mtlo: write alu_src1 at the clock edge where the register advances.
- Divider FSM:
  - IDLE: a div/divu in EX and not yet done -> BUSY, latching operands; stallreq=1.
  - BUSY: one restoring step per cycle, DIV_CYCLES steps; stallreq=1.
  - DONE: HI<=remainder, LO<=quotient on entry; stallreq=0; stays until the register advances or bubbles, then IDLE.
- Signed divide: operate on magnitudes; quotient negated if signs differ; remainder takes the dividend's sign.
- Divide by zero: quotient 0xFFFFFFFF, remainder = dividend, same latency.
- Total: div in EX at cycle T -> stallreq high cycles T..T+32, low at T+33, HI/LO valid from T+33.
- Divide writes rf_we=0 (bus field is forced to 0).
- Async reset mid-divide -> IDLE, HI=LO=0.

Optional Feature:
EX_DIV_ZERO_SKIP_EN
- Defined: divisor==0 or dividend==0 -> BUSY lasts one cycle; the result equals the normal-path value.
  - Divide-by-zero: quotient 0xFFFFFFFF, remainder = dividend.
  - Zero dividend: 0/0.
- Undefined: always DIV_CYCLES.

Decomposition:
- Shared defines package:
  - ID_TO_EX_WD and EX_TO_MEM_WD.
  - EX_TO_ID_WD=38.
  - StallBus, Stop/NoStop.
  - LOAD_SRAM_DATA_WD=5, STORE_SRAM_DATA_WD=3.
  - ALU one-hot bit indices, mem_op/hilo_op bit indices.
  - Divider FSM state encodings.
- One sub-module: div_iter (operands, signed flag, start -> quotient, remainder, done), containing the FSM and the shift/subtract datapath.

Test Plan:
- Reset low mid-run -> all outputs 0, stallreq_for_ex=0; release -> first instruction appears one clock after stall[2]=NoStop.
- sb, store_data=0x000000AB, addr 0x1002:
  - data_sram_en=1, wen=0100, wdata=0xABABABAB, addr=0x1002.
  - Bus data_ram_wen=0100.
- lh at addr 0x2002 -> data_sram_wen=0000, bus data_ram_wen=1100, load_sram_ex_data=01000, sel_rf_res=1.
- div -7/2 -> stallreq high exactly 33 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; subsequent mflo/mfhi return those values.
- divu 5/0 -> LO=0xFFFFFFFF, HI=5; 33 stall cycles, or 2 with EX_DIV_ZERO_SKIP_EN.
- stall=6'b000111 with add in EX -> bubble to MEM (ex_to_mem_bus=0 next cycle); stall=6'b001111 -> EX register holds its value.
